muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, attached beside the ALU in the EX stage of the pipelined datapath.
- Accepts one operation per start pulse and computes all eight M-extension operations selected by funct3.
- Holds busy so the hazard logic stalls IF/ID/EX.
- Parametrised in operand width; optional single-cycle multiply mode.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// with single-cycle fast paths for divide-by-zero, signed overflow and optional MUL.
module muldiv_unit #(
  parameter int DATA_W   = 32,
  parameter bit MUL_FAST = 1'b0,
  parameter int CNT_W    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int W = DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             a_neg, b_neg, b_zero, ovf;
  logic [W-1:0]     mag_a, mag_b;
  logic [2*W-1:0]   fast_prod;
  logic [W:0]       sum, shifted, diff;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic neg);
    logic signed [W-1:0] s;
    s = v;
    return neg ? W'(-s) : v;
  endfunction

  // Apply sign correction to the unsigned accumulator and pick the requested half.
  function automatic logic [W-1:0] finish_res(input logic [2:0] f3, input logic [2*W-1:0] acc,
                                              input logic sa, input logic sb);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;
    prod = (sa ^ sb) ? -acc : acc;
    quo  = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
    rem  = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (f3)
      3'b000:                 return prod[W-1:0];
      3'b001, 3'b010, 3'b011: return prod[2*W-1:W];
      3'b100, 3'b101:         return quo;
      default:                return rem;
    endcase
  endfunction

  always_comb begin
    a_neg     = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111) && op_a[W-1];
    b_neg     = ((funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110)) && op_b[W-1];
    mag_a     = magnitude(op_a, a_neg);
    mag_b     = magnitude(op_b, b_neg);
    b_zero    = (op_b == '0);
    ovf       = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
    fast_prod = {{W{1'b0}}, mag_a} * {{W{1'b0}}, mag_b};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          sa_d  = a_neg;
          sb_d  = b_neg;
          opb_d = mag_b;
          acc_d = {{W{1'b0}}, mag_a};
          cnt_d = CNT_W'(W);
          if (funct3[2] && b_zero) begin
            result_d = funct3[1] ? op_a : '1;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else if (ovf) begin
            result_d = funct3[1] ? '0 : op_a;
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else if (MUL_FAST && !funct3[2]) begin
            result_d = finish_res(funct3, fast_prod, a_neg, b_neg);
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!f3_q[2]) begin
          sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
          acc_d = {sum, acc_q[W-1:1]};
        end else begin
          shifted = {acc_q[2*W-1:W], acc_q[W-1]};
          diff    = shifted - {1'b0, opb_q};
          if (!diff[W]) acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
          else          acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = finish_res(f3_q, acc_d, sa_q, sb_q);
          done_d   = 1'b1;
          state_d  = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // done/result are registered on entry to FIN, so a flush on that edge drops both.
    if (flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: iterative instance plus a MUL_FAST instance.
module tb_muldiv_unit;

  logic        clk, reset;
  logic        start, flush, start_f, flush_f;
  logic [2:0]  funct3, funct3_f;
  logic [31:0] op_a, op_b, op_a_f, op_b_f;
  logic        busy, done, busy_f, done_f;
  logic [31:0] result, result_f;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t qf[$];
  exp_t e, ef;
  int   cyc;
  int   n_chk, n_pass;

  muldiv_unit #(.DATA_W(32), .MUL_FAST(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.DATA_W(32), .MUL_FAST(1'b1)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .funct3(funct3_f), .op_a(op_a_f), .op_b(op_b_f),
    .flush(flush_f), .busy(busy_f), .done(done_f), .result(result_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    if (push) q.push_back('{exp, cyc + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_f(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    start_f = 1'b1; funct3_f = f; op_a_f = a; op_b_f = b;
    qf.push_back('{exp, cyc + lat});
    @(negedge clk);
    start_f = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && qf.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(q.size() + qf.size()), 32'd0);
    q.delete();
    qf.delete();
    @(negedge clk);
  endtask

  // Monitor: every done is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done_f) begin
        if (qf.size() == 0) chk("unexpected_done_fast", 32'(done_f), 32'd0);
        else begin
          ef = qf.pop_front();
          chk("result_fast", result_f, ef.res);
          chk("done_cycle_fast", 32'(cyc), 32'(ef.cyc));
        end
      end
    end
  end

  initial begin
    int t;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    start_f = 1'b0; flush_f = 1'b0; funct3_f = '0; op_a_f = '0; op_b_f = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_busy_fast", 32'(busy_f), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fast-multiply instance
    issue_f(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    wait_done();
    issue_f(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    wait_done();
    issue_f(3'b101, 32'd100, 32'd7, 32'd14, 33);
    wait_done();

    // Iterative MUL with an ignored start while busy
    t = cyc;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    chk("mul_busy_t1", 32'(busy), 32'd1);
    wait_until(t + 5);
    issue(3'b000, 32'd2, 32'd3, 32'd6, 0, 1'b0);
    wait_until(t + 33);
    chk("mul_busy_t33", 32'(busy), 32'd1);
    wait_until(t + 34);
    chk("mul_busy_t34", 32'(busy), 32'd0);
    wait_done();

    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b1); wait_done();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1); wait_done();
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1); wait_done();

    // Single-cycle corner cases
    issue(3'b101, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b1); wait_done();
    issue(3'b110, 32'h1234, 32'd0, 32'h1234, 1, 1'b1); wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1); wait_done();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1); wait_done();

    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1); wait_done();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1); wait_done();
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1); wait_done();
    issue(3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1); wait_done();

    // Flush mid-divide, then restart right away
    t = cyc;
    issue(3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    wait_until(t + 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_hold", result, 32'd2);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    wait_until(t + 40);
    chk("flush_no_early_done", 32'(q.size()), 32'd1);
    wait_done();

    // Flush and start together in IDLE
    flush = 1'b1;
    issue(3'b101, 32'd50, 32'd5, 32'd0, 0, 1'b0);
    flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_start_result", result, 32'd14);

    // Reset mid-multiply
    t = cyc;
    issue(3'b000, 32'd9, 32'd9, 32'd0, 0, 1'b0);
    wait_until(t + 20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    repeat (40) @(negedge clk);
    chk("final_queue", 32'(q.size() + qf.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
